// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//
// Purpose:
//    Single-issue front end for an external combinational ALU. The block
//    accepts one 16-bit instruction at a time and steps it through
//    DECODE, EXEC and DONE. It drives registered operands to the ALU and
//    captures the ALU outputs. It writes the result back into a
//    4-entry register file and presents a completion record until the
//    consumer takes it.
//
// Ports:
//    clk, reset_n        clock (rising edge), asynchronous active-low reset
//    in_valid/in_ready   instruction handshake (in_ready only in IDLE)
//    in_instr, in_pc     instruction word and its address
//    alu_opcode/funcode  registered opcode and funcode driven to the ALU
//    alu_a, alu_b        registered ALU operands
//    alu_result/bcond    ALU outputs, sampled in EXEC
//    cmpl_valid/ready    completion handshake (cmpl_valid only in DONE)
//    cmpl_result/taken/target/illegal   completion payload
//    dbg_sel, dbg_data   combinational register-file read
//    num_inst            completion counter (only with ALU_ISSUE_CNT_EN)
//
// Configuration:
//    ALU_ISSUE_CNT_EN    when defined, adds the num_inst output and the
//                        completion-handshake counter behind it.
// ---------------------------------------------------------------------------
module alu_issue (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_instr,
   input  logic [15:0] in_pc,
   output logic [3:0]  alu_opcode,
   output logic [5:0]  alu_funcode,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   input  logic [15:0] alu_result,
   input  logic        alu_bcond,
   output logic        cmpl_valid,
   input  logic        cmpl_ready,
   output logic [15:0] cmpl_result,
   output logic        cmpl_taken,
   output logic [15:0] cmpl_target,
   output logic        cmpl_illegal,
   input  logic [1:0]  dbg_sel,
   output logic [15:0] dbg_data
`ifdef ALU_ISSUE_CNT_EN
   ,
   output logic [15:0] num_inst
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      DECODE,
      EXEC,
      DONE
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [15:0] instr_q;
   logic [15:0] pc_q;
   logic [15:0] rf [4];

   logic [3:0]  op;
   logic [1:0]  rs;
   logic [1:0]  rt;
   logic [1:0]  rd;
   logic [5:0]  fn;
   logic [7:0]  imm;
   logic [15:0] imm_sext;
   logic [15:0] imm_zext;
   logic        is_branch;
   logic        is_illegal;
   logic        wr_en;
   logic [1:0]  wr_addr;

   // Field split of the latched instruction; imm overlaps rd/funcode.
   assign op       = instr_q[15:12];
   assign rs       = instr_q[11:10];
   assign rt       = instr_q[9:8];
   assign rd       = instr_q[7:6];
   assign fn       = instr_q[5:0];
   assign imm      = instr_q[7:0];
   assign imm_sext = {{8{imm[7]}}, imm};
   assign imm_zext = {8'h00, imm};

   assign is_branch  = (op <= 4'd3);
   assign is_illegal = ((op >= 4'd9) && (op <= 4'd14)) ||
                       ((op == 4'd15) && (fn > 6'd7));

   assign in_ready   = (state == IDLE);
   assign cmpl_valid = (state == DONE);
   assign dbg_data   = rf[dbg_sel];

   // Write-back decode. It is only active in EXEC, so the write lands on the
   // EXEC->DONE edge and comes before the next instruction's DECODE.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = rt;
      if (state == EXEC) begin
         if ((op == 4'd15) && (fn <= 6'd7)) begin
            wr_en   = 1'b1;
            wr_addr = rd;
         end else if ((op == 4'd4) || (op == 4'd5) || (op == 4'd6)) begin
            wr_en   = 1'b1;
            wr_addr = rt;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: one cycle each in DECODE and EXEC, and DONE waits for
   // the consumer.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = DECODE;
         DECODE:  state_next = EXEC;
         EXEC:    state_next = DONE;
         DONE:    if (cmpl_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Instruction and PC capture on acceptance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr_q <= 16'h0000;
         pc_q    <= 16'h0000;
      end else if ((state == IDLE) && in_valid) begin
         instr_q <= in_instr;
         pc_q    <= in_pc;
      end
   end

   // Operand registers for the ALU. They are loaded in DECODE and then held
   // so that the ALU output settles for a full cycle before EXEC samples it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_opcode  <= 4'h0;
         alu_funcode <= 6'h00;
         alu_a       <= 16'h0000;
         alu_b       <= 16'h0000;
      end else if (state == DECODE) begin
         alu_opcode  <= op;
         alu_funcode <= fn;
         alu_a       <= rf[rs];
         case (op)
            4'd0, 4'd1, 4'd15: alu_b <= rf[rt];
            4'd4, 4'd7, 4'd8:  alu_b <= imm_sext;
            4'd5, 4'd6:        alu_b <= imm_zext;
            default:           alu_b <= 16'h0000;
         endcase
      end
   end

   // Completion payload. It is captured in EXEC and holds through DONE
   // until the consumer accepts it. Only branches report taken or a
   // target, and illegal encodings never report taken.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmpl_result  <= 16'h0000;
         cmpl_taken   <= 1'b0;
         cmpl_target  <= 16'h0000;
         cmpl_illegal <= 1'b0;
      end else if (state == EXEC) begin
         cmpl_result  <= alu_result;
         cmpl_taken   <= alu_bcond & is_branch & ~is_illegal;
         cmpl_target  <= is_branch ? (pc_q + 16'd1 + imm_sext) : 16'h0000;
         cmpl_illegal <= is_illegal;
      end
   end

   // Register file. When rs, rt and rd alias, DECODE has already read the
   // old value, so this write only replaces it afterwards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            rf[i] <= 16'h0000;
         end
      end else if (wr_en) begin
         rf[wr_addr] <= alu_result;
      end
   end

`ifdef ALU_ISSUE_CNT_EN
   // Completion counter. It steps on each DONE handshake and wraps naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         num_inst <= 16'h0000;
      end else if ((state == DONE) && cmpl_ready) begin
         num_inst <= num_inst + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
//
// Purpose:
//    Self-checking bench for alu_issue. A behavioural ALU stub answers the
//    DUT's operand requests. A register-array reference model predicts
//    every completion record and every register-file update from the
//    instruction fields alone.
//
// Ports: none (top-level bench).
//
// Configuration:
//    ALU_ISSUE_CNT_EN    when defined, the num_inst counter is checked too.
// ---------------------------------------------------------------------------
module tb_alu_issue;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic [15:0] in_pc;
   logic [3:0]  alu_opcode;
   logic [5:0]  alu_funcode;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_result;
   logic        alu_bcond;
   logic        cmpl_valid;
   logic        cmpl_ready;
   logic [15:0] cmpl_result;
   logic        cmpl_taken;
   logic [15:0] cmpl_target;
   logic        cmpl_illegal;
   logic [1:0]  dbg_sel;
   logic [15:0] dbg_data;
`ifdef ALU_ISSUE_CNT_EN
   logic [15:0] num_inst;
`endif

   int          assertCount = 0;
   int          failCount   = 0;
   logic [15:0] refRf [4];

   alu_issue dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .alu_opcode   (alu_opcode),
      .alu_funcode  (alu_funcode),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_result   (alu_result),
      .alu_bcond    (alu_bcond),
      .cmpl_valid   (cmpl_valid),
      .cmpl_ready   (cmpl_ready),
      .cmpl_result  (cmpl_result),
      .cmpl_taken   (cmpl_taken),
      .cmpl_target  (cmpl_target),
      .cmpl_illegal (cmpl_illegal),
      .dbg_sel      (dbg_sel),
      .dbg_data     (dbg_data)
`ifdef ALU_ISSUE_CNT_EN
      ,
      .num_inst     (num_inst)
`endif
   );

   // Free-running clock with a 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational ALU stub. It is driven from the DUT's operand registers.
   // Branches 0..3 are BNE, BEQ, BGZ and BLZ. Opcode 15 selects the R-type
   // operation by funcode.
   always_comb begin
      alu_result = 16'h0000;
      alu_bcond  = 1'b0;
      case (alu_opcode)
         4'd0: alu_bcond = (alu_a != alu_b);
         4'd1: alu_bcond = (alu_a == alu_b);
         4'd2: alu_bcond = ($signed(alu_a) > 0);
         4'd3: alu_bcond = ($signed(alu_a) < 0);
         4'd5: alu_result = alu_a | alu_b;
         4'd6: alu_result = {alu_b[7:0], 8'h00};
         4'd15: begin
            case (alu_funcode)
               6'd0:    alu_result = alu_a + alu_b;
               6'd1:    alu_result = alu_a - alu_b;
               6'd2:    alu_result = alu_a & alu_b;
               6'd3:    alu_result = alu_a | alu_b;
               6'd4:    alu_result = ~alu_a;
               6'd5:    alu_result = ~alu_a + 16'd1;
               6'd6:    alu_result = alu_a << 1;
               6'd7:    alu_result = $signed(alu_a) >>> 1;
               default: alu_result = alu_a + alu_b;
            endcase
         end
         default: alu_result = alu_a + alu_b;
      endcase
   end

   // Single comparison point: counts the comparison and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Compare all four architectural registers against the model.
   task automatic checkRegs(input string tag);
      for (int i = 0; i < 4; i++) begin
         dbg_sel = 2'(i);
         #1;
         checkOutput($sformatf("%s_rf%0d", tag, i), dbg_data, refRf[i]);
      end
   endtask

   // Asynchronous reset. The model registers are cleared along with the DUT.
   task automatic doReset();
      in_valid   = 1'b0;
      cmpl_ready = 1'b0;
      in_instr   = 16'h0000;
      in_pc      = 16'h0000;
      dbg_sel    = 2'd0;
      reset_n    = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) refRf[i] = 16'h0000;
   endtask

   // Issue one instruction. The call starts at a negedge with the DUT idle.
   // holdCycles is the number of cycles cmpl_ready stays low in DONE. The
   // task returns at the negedge after the handshake, so a follow-up call
   // runs back-to-back.
   task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] pc,
                                input int holdCycles);
      logic [3:0]  op;
      logic [1:0]  rs, rt, rd;
      logic [5:0]  fn;
      logic [7:0]  imm;
      logic [15:0] a, b, se, ze, res, target;
      logic        taken, illegal, wr, chkRes;
      logic [1:0]  wrAddr;

      op  = instr[15:12];
      rs  = instr[11:10];
      rt  = instr[9:8];
      rd  = instr[7:6];
      fn  = instr[5:0];
      imm = instr[7:0];
      a   = refRf[rs];
      b   = refRf[rt];
      se  = {{8{imm[7]}}, imm};
      ze  = {8'h00, imm};
      illegal = ((op >= 4'd9) && (op <= 4'd14)) || ((op == 4'd15) && (fn > 6'd7));
      taken   = 1'b0;
      target  = 16'h0000;
      res     = 16'h0000;
      wr      = 1'b0;
      chkRes  = 1'b0;
      wrAddr  = rt;
      case (op)
         4'd0: taken = (a != b);
         4'd1: taken = (a == b);
         4'd2: taken = ($signed(a) > 0);
         4'd3: taken = ($signed(a) < 0);
         4'd4: begin res = a + se;        wr = 1'b1; chkRes = 1'b1; end
         4'd5: begin res = a | ze;        wr = 1'b1; chkRes = 1'b1; end
         4'd6: begin res = {imm, 8'h00};  wr = 1'b1; chkRes = 1'b1; end
         4'd15: begin
            if (!illegal) begin
               wr = 1'b1; chkRes = 1'b1; wrAddr = rd;
               case (fn[2:0])
                  3'd0: res = a + b;
                  3'd1: res = a - b;
                  3'd2: res = a & b;
                  3'd3: res = a | b;
                  3'd4: res = ~a;
                  3'd5: res = 16'd0 - a;
                  3'd6: res = {a[14:0], 1'b0};
                  default: res = {a[15], a[15:1]};
               endcase
            end
         end
         default: ;
      endcase
      if (op <= 4'd3) target = pc + 16'd1 + se;

      checkOutput("in_ready_idle", 16'(in_ready), 16'd1);
      in_instr   = instr;
      in_pc      = pc;
      in_valid   = 1'b1;
      cmpl_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("valid_decode", 16'(cmpl_valid), 16'd0);
      checkOutput("in_ready_decode", 16'(in_ready), 16'd0);
      @(negedge clk);
      checkOutput("valid_exec", 16'(cmpl_valid), 16'd0);
      checkOutput("alu_opcode", 16'(alu_opcode), 16'(op));
      checkOutput("alu_a", alu_a, a);
      @(negedge clk);
      for (int h = 0; h <= holdCycles; h++) begin
         checkOutput("valid_done", 16'(cmpl_valid), 16'd1);
         checkOutput("in_ready_done", 16'(in_ready), 16'd0);
         checkOutput("cmpl_taken", 16'(cmpl_taken), 16'(taken));
         checkOutput("cmpl_target", cmpl_target, target);
         checkOutput("cmpl_illegal", 16'(cmpl_illegal), 16'(illegal));
         if (chkRes) checkOutput("cmpl_result", cmpl_result, res);
         if (h < holdCycles) @(negedge clk);
      end
      cmpl_ready = 1'b1;
      @(negedge clk);
      cmpl_ready = 1'b0;
      checkOutput("valid_after_hs", 16'(cmpl_valid), 16'd0);
      if (wr) refRf[wrAddr] = res;
      checkRegs("wb");
   endtask

   initial begin
      logic [15:0] rInstr;
      logic [15:0] rPc;

      $display("[TB] starting alu_issue bench");
      doReset();

      // Reset state.
      checkOutput("rst_in_ready", 16'(in_ready), 16'd1);
      checkOutput("rst_cmpl_valid", 16'(cmpl_valid), 16'd0);
      checkOutput("rst_alu_opcode", 16'(alu_opcode), 16'd0);
      checkOutput("rst_alu_funcode", 16'(alu_funcode), 16'd0);
      checkOutput("rst_alu_a", alu_a, 16'd0);
      checkOutput("rst_alu_b", alu_b, 16'd0);
      checkOutput("rst_cmpl_result", cmpl_result, 16'd0);
      checkOutput("rst_cmpl_taken", 16'(cmpl_taken), 16'd0);
      checkOutput("rst_cmpl_target", cmpl_target, 16'd0);
      checkOutput("rst_cmpl_illegal", 16'(cmpl_illegal), 16'd0);
      checkRegs("rst");
`ifdef ALU_ISSUE_CNT_EN
      checkOutput("rst_num_inst", num_inst, 16'd0);
`endif

      // ADI rt=1 rs=0 imm=0xFF writes 0xFFFF.
      applyStimulus(16'h41FF, 16'h0000, 0);
      checkOutput("adi_rf1", refRf[1], 16'hFFFF);
      // rf[2]=1, then ADD rd=3 wraps to 0, then back-to-back SUB rd=0 gives 0xFFFF.
      applyStimulus(16'h4201, 16'h0001, 0);
      applyStimulus(16'hF6C0, 16'h0002, 0);
      applyStimulus(16'hFE01, 16'h0003, 0);
      // rf[1]=rf[2]=5, then BEQ at pc 0x0010 with imm 0xFE goes to 0x000F.
      applyStimulus(16'h4D05, 16'h0004, 0);
      applyStimulus(16'h4E05, 16'h0005, 0);
      applyStimulus(16'h16FE, 16'h0010, 0);
      // Illegal encodings, then LHI rt=2 imm=0x12.
      applyStimulus(16'h9123, 16'h0020, 0);
      applyStimulus(16'hF6D9, 16'h0021, 0);
      applyStimulus(16'h6212, 16'h0022, 0);
      // Consumer stalls for five cycles.
      applyStimulus(16'hF4C0, 16'h0030, 5);

      // Reset pulsed while an instruction is in EXEC.
      in_instr = 16'h41FF;
      in_pc    = 16'h0040;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midrst_in_ready", 16'(in_ready), 16'd1);
      checkOutput("midrst_valid", 16'(cmpl_valid), 16'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) refRf[i] = 16'h0000;
      repeat (3) @(negedge clk);
      checkOutput("midrst_valid_late", 16'(cmpl_valid), 16'd0);
      checkOutput("midrst_in_ready_late", 16'(in_ready), 16'd1);
      checkRegs("midrst");

      // Randomised instruction stream against the reference model.
      for (int n = 0; n < 60; n++) begin
         rInstr = 16'($urandom);
         rPc    = 16'($urandom);
         applyStimulus(rInstr, rPc, int'($urandom_range(0, 2)));
      end

`ifdef ALU_ISSUE_CNT_EN
      doReset();
      checkOutput("cnt_after_reset", num_inst, 16'd0);
      applyStimulus(16'h4101, 16'h0000, 0);
      applyStimulus(16'h9000, 16'h0001, 1);
      applyStimulus(16'h1500, 16'h0002, 0);
      checkOutput("cnt_three", num_inst, 16'd3);
      doReset();
      checkOutput("cnt_cleared", num_inst, 16'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
